rvvi_trace_sequencer: RTL
=========================

Name: rvvi_trace_sequencer

Overview:
Buffers per-retirement trace events from the core's RVFI signals in a small FIFO and drains them one per handshake to an RVVI-side consumer (tracer, comparator, reference-model stepper).
- Decodes rd into the one-hot X-register writeback vector the RVVI trace format uses.
- Checks that retirement order is contiguous.
- Flags overflow, because the retire side cannot be back-pressured.
- Sits in the testbench between the core's RVFI signals and the RVVI trace consumer.

Parameters:
DEPTH, 8, FIFO entries; power of two, >= 2
HALT_ON_ERR, 1, 1 = stop draining after the first order error

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
ret_valid_i  in  1  retirement event this cycle
ret_order_i  in  64  retirement order number
ret_pc_i  in  32  pc_rdata
ret_insn_i  in  32  instruction word
ret_trap_i  in  1  trap flag
ret_rd_addr_i  in  5  destination register
ret_rd_wdata_i  in  32  destination write data
trc_valid_o  out  1  trace entry available
trc_ready_i  in  1  consumer accepts entry
trc_order_o  out  64  order of head entry
trc_pc_o  out  32  pc of head entry
trc_insn_o  out  32  insn of head entry
trc_trap_o  out  1  trap of head entry
trc_x_wb_o  out  32  one-hot X writeback flags
trc_x_wdata_o  out  32  write data for the flagged register
level_o  out  $clog2(DEPTH)+1  current occupancy
overflow_o  out  1  sticky: a retirement was dropped
order_err_o  out  1  sticky: order discontinuity seen
err_order_o  out  64  order value that first mismatched
state_o  out  2  RUN=0, STOPPED=1

Behaviour:
- Reset: rst_i sampled on the clk_i edge.
  - All outputs 0.
  - FIFO empty.
  - Expected order = 0.
  - State RUN.
  - Reset mid-stream discards all buffered entries and clears the sticky flags.
- Push: on ret_valid_i=1 and (not full, or a pop in the same cycle), write the entry at the tail.
  - The entry becomes visible at the head, if the FIFO was empty, on the next cycle (1-cycle latency; no same-cycle bypass).
- Full without a simultaneous pop: drop the event and set overflow_o.
  - The expected-order counter still advances by 1, so the drop does not also raise order_err_o.
- Pop: occurs when trc_valid_o && trc_ready_i.
  - The head advances.
  - trc_* outputs are held stable while trc_valid_o=1 and trc_ready_i=0.
- Simultaneous push and pop at full: both occur; level unchanged.
- Simultaneous push and pop at empty: only the push is meaningful, because trc_valid_o=0.
- Pointers: $clog2(DEPTH)+1 bits with natural wrap. Full = MSBs differ and the rest are equal.
- trc_valid_o = !empty && state==RUN.
- Order check on every ret_valid_i:
  - If ret_order_i != expected and order_err_o=0: set order_err_o and latch err_order_o = ret_order_i.
  - In all cases expected <= ret_order_i + 1 (64-bit wrap), so checking resynchronises after an error.
- State machine:
  - RUN -> STOPPED on the first order error when HALT_ON_ERR=1.
  - STOPPED is left only by reset.
  - In STOPPED, pushes still fill the FIFO (overflow rules unchanged) and trc_valid_o=0.
- Writeback decode: computed from the head entry.
  - trc_x_wb_o = (rd!=0) ? 1<<rd : 0.
  - trc_x_wdata_o = (rd!=0) ? wdata : 0.
  - x0 is never flagged.
- level_o = tail - head.

Decomposition:
- Package rvvi_trace_pkg:
  - trace_entry_t struct {order, pc, insn, trap, rd_addr, rd_wdata}.
  - state_e enum.
  - Function decode_xwb(rd, data).
- One sub-module: trace_fifo, a generic show-ahead FIFO of trace_entry_t with DEPTH. Full/empty/level logic lives there.
- The order checker, FSM and decode stay in the top level.

Test Plan:
- Reset, then 3 retirements with order 0,1,2, rd=5, wdata 0xA5, and ready=1 -> three handshakes in order; x_wb = 0x20, x_wdata = 0xA5; order_err_o=0.
- ready=0, push DEPTH+2 events (orders 0..9, DEPTH=8) -> level_o=8, overflow_o=1 at the 9th; raising ready drains orders 0..7 only; order_err_o=0.
- Retire order 0,1,3 with HALT_ON_ERR=1 -> order_err_o=1, err_order_o=3, state STOPPED, trc_valid_o=0 after entry 1 drains.
- FIFO full and ready=1 with ret_valid_i=1 in the same cycle -> level stays 8, no overflow, next pushed order appears after the drain.
- rd=0, wdata 0xDEADBEEF -> x_wb=0, x_wdata=0.
- Assert rst_i with 4 entries buffered -> next cycle trc_valid_o=0, level_o=0, sticky flags 0, expected order 0.

Source files
------------

// File: rtl/rvvi_trace_pkg.sv
// rtl/rvvi_trace_pkg.sv - shared types and writeback decode for the RVVI trace sequencer
package rvvi_trace_pkg;

  typedef struct packed {
    logic [63:0] order;
    logic [31:0] pc;
    logic [31:0] insn;
    logic        trap;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
  } trace_entry_t;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_STOPPED = 2'd1
  } state_e;

  typedef struct packed {
    logic [31:0] wb;
    logic [31:0] wdata;
  } xwb_t;

  // x0 is hardwired, so it is never reported as written
  function automatic xwb_t decode_xwb(input logic [4:0] rd, input logic [31:0] data);
    xwb_t r;
    r.wb    = '0;
    r.wdata = '0;
    if (rd != 5'd0) begin
      r.wb[rd] = 1'b1;
      r.wdata  = data;
    end
    return r;
  endfunction

endpackage

// File: rtl/rvvi_trace_fifo.sv
// rtl/rvvi_trace_fifo.sv - show-ahead FIFO of trace entries
module trace_fifo
  import rvvi_trace_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  trace_entry_t             push_data,
  input  logic                     pop,
  output trace_entry_t             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  trace_entry_t mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  // Pointer update; the extra MSB distinguishes full from empty
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset because empty masks them
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // Status flags and head read
  always_comb begin
    empty = (wr_ptr == rd_ptr);
    full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    level = wr_ptr - rd_ptr;
    head  = mem[rd_ptr[AW-1:0]];
  end

endmodule

// File: rtl/rvvi_trace_sequencer.sv
// rtl/rvvi_trace_sequencer.sv - buffers RVFI retirements and drains them as RVVI trace entries
module rvvi_trace_sequencer
  import rvvi_trace_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter bit HALT_ON_ERR = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   ret_valid_i,
  input  logic [63:0]            ret_order_i,
  input  logic [31:0]            ret_pc_i,
  input  logic [31:0]            ret_insn_i,
  input  logic                   ret_trap_i,
  input  logic [4:0]             ret_rd_addr_i,
  input  logic [31:0]            ret_rd_wdata_i,
  output logic                   trc_valid_o,
  input  logic                   trc_ready_i,
  output logic [63:0]            trc_order_o,
  output logic [31:0]            trc_pc_o,
  output logic [31:0]            trc_insn_o,
  output logic                   trc_trap_o,
  output logic [31:0]            trc_x_wb_o,
  output logic [31:0]            trc_x_wdata_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   overflow_o,
  output logic                   order_err_o,
  output logic [63:0]            err_order_o,
  output logic [1:0]             state_o
);

  state_e       state, state_nxt;
  trace_entry_t wr_entry, head;
  logic         full, empty, push, pop, first_err;
  logic [63:0]  exp_order;
  xwb_t         xwb;

  assign wr_entry  = '{order: ret_order_i, pc: ret_pc_i, insn: ret_insn_i,
                       trap: ret_trap_i, rd_addr: ret_rd_addr_i, rd_wdata: ret_rd_wdata_i};
  assign pop       = trc_valid_o && trc_ready_i;
  assign push      = ret_valid_i && (!full || pop);
  assign first_err = ret_valid_i && (ret_order_i != exp_order) && !order_err_o;

  trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (push),
    .push_data (wr_entry),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .level     (level_o)
  );

  // Order checker and sticky flags; expected order always resyncs to the last seen + 1
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      exp_order   <= '0;
      overflow_o  <= 1'b0;
      order_err_o <= 1'b0;
      err_order_o <= '0;
    end else begin
      if (ret_valid_i) exp_order <= ret_order_i + 64'd1;
      if (first_err) begin
        order_err_o <= 1'b1;
        err_order_o <= ret_order_i;
      end
      if (ret_valid_i && full && !pop) overflow_o <= 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= ST_RUN;
    else       state <= state_nxt;
  end

  // Next state: halt draining on the first order error when configured to
  always_comb begin
    state_nxt = state;
    if (state == ST_RUN && HALT_ON_ERR && first_err) state_nxt = ST_STOPPED;
  end

  // Outputs: handshake, state and head-entry fields (zeroed while empty)
  always_comb begin
    xwb           = decode_xwb(head.rd_addr, head.rd_wdata);
    trc_valid_o   = !empty && (state == ST_RUN);
    state_o       = state;
    trc_order_o   = empty ? '0 : head.order;
    trc_pc_o      = empty ? '0 : head.pc;
    trc_insn_o    = empty ? '0 : head.insn;
    trc_trap_o    = empty ? 1'b0 : head.trap;
    trc_x_wb_o    = empty ? '0 : xwb.wb;
    trc_x_wdata_o = empty ? '0 : xwb.wdata;
  end

endmodule
